// File: rtl/fifo_rd_stream_if.sv
// Bundles the FIFO read port and the output stream of fifo_rd_stream.
// The master modport is the streamer's view; the slave modport is the
// view of the surrounding FIFO and downstream sink.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_rd_o;
    logic [DATA_WIDTH-1:0] fifo_rd_data_i;
    logic                  fifo_empty_i;
    logic                  tvalid_o;
    logic                  tready_i;
    logic [DATA_WIDTH-1:0] tdata_o;
    logic                  tlast_o;
    logic [15:0]           beat_cnt_o;

    modport master (
        output fifo_rd_o,
        input  fifo_rd_data_i,
        input  fifo_empty_i,
        output tvalid_o,
        input  tready_i,
        output tdata_o,
        output tlast_o,
        output beat_cnt_o
    );

    modport slave (
        input  fifo_rd_o,
        output fifo_rd_data_i,
        output fifo_empty_i,
        input  tvalid_o,
        output tready_i,
        input  tdata_o,
        input  tlast_o,
        input  beat_cnt_o
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Reads words from a single-clock FIFO with one-cycle read latency and
// presents them as a valid/ready stream with packet framing. A 2-entry
// in-order buffer absorbs the read latency so a ready sink sees one beat
// per clock. Reads are issued only when the buffer is guaranteed to have
// room for the returning word.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    fifo_rd_stream_if.master  bus
);

    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    // Control state
    logic                  run_q;        // set on first clock edge after reset release
    logic [1:0]            occ_q;        // words held in the buffer
    logic [1:0]            occ_d;
    logic                  inflight_q;   // read issued last cycle, data arrives now
    logic [15:0]           beat_q;
    logic [15:0]           beat_d;

    // Buffer storage: head is presented on the stream, tail is the second slot
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [DATA_WIDTH-1:0] tail_d;

    logic                  pop;
    logic                  rd;
    logic [2:0]            level;        // occupancy after this cycle's pop and capture

    // Read decision, buffer shift/capture and beat counter next-state
    always_comb begin
        pop    = (occ_q != 2'd0) && bus.tready_i;
        level  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd     = run_q && !bus.fifo_empty_i && (level < 3'd2);

        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (pop) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end
        // The returning word lands in the first free slot after the pop shift,
        // which keeps ordering intact when capture and pop coincide.
        if (inflight_q) begin
            if (occ_d == 2'd0) begin
                head_d = bus.fifo_rd_data_i;
            end else begin
                tail_d = bus.fifo_rd_data_i;
            end
            occ_d = occ_d + 2'd1;
        end

        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? 16'd0 : beat_q + 16'd1;
        end
    end

    // Control registers and stream head; async clear also drops any read in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q      <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= 16'd0;
            head_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            occ_q      <= occ_d;
            inflight_q <= rd;
            beat_q     <= beat_d;
            head_q     <= head_d;
        end
    end

    // Second buffer slot is pure data; its content is meaningless while occ < 2
    always_ff @(posedge clk_i) begin
        tail_q <= tail_d;
    end

    assign bus.fifo_rd_o  = rd;
    assign bus.tvalid_o   = (occ_q != 2'd0);
    assign bus.tdata_o    = head_q;
    assign bus.tlast_o    = (occ_q != 2'd0) && (beat_q == LAST_BEAT);
    assign bus.beat_cnt_o = beat_q;

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the data word width in bits.
REQ-002 The module SHALL have parameter PKT_LEN, default 16, meaning beats per packet (range 1..65535) used for tlast_o generation.
REQ-003 clk_i  input  1  single clock; all logic is rising-edge.
REQ-004 rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 fifo_rd_o  output  1  read request to the upstream single-clock FIFO.
REQ-006 fifo_rd_data_i  input  DATA_WIDTH  FIFO read data, valid exactly one cycle after the accepted read.
REQ-007 fifo_empty_i  input  1  FIFO empty flag.
REQ-008 tvalid_o  output  1  stream word valid.
REQ-009 tready_i  input  1  downstream accepts the word.
REQ-010 tdata_o  output  DATA_WIDTH  stream data.
REQ-011 tlast_o  output  1  high on the last beat of each PKT_LEN-beat packet.
REQ-012 beat_cnt_o  output  16  index of the current beat within the packet, 0..PKT_LEN-1.

Function
REQ-013 Transfer (pop) SHALL occur in a cycle where tvalid_o && tready_i.
REQ-014 The block SHALL hold a 2-entry in-order output buffer; occ (0..2) SHALL count the words held.
REQ-015 The block SHALL track inflight (0..1), meaning a read issued last cycle whose data arrives this cycle.
REQ-016 fifo_rd_o SHALL equal !fifo_empty_i && (occ + inflight - pop < 2), combinational in the same cycle.
REQ-017 The block SHALL never assert fifo_rd_o while fifo_empty_i is high.
REQ-018 The block SHALL never issue a read that could overflow the buffer.
REQ-019 The block SHALL write fifo_rd_data_i into the buffer tail on the clock edge ending the cycle in which inflight=1.
REQ-020 tvalid_o SHALL equal (occ != 0), driven from registers only.
REQ-021 tdata_o SHALL be the buffer head, driven from registers only.
REQ-022 tdata_o and tvalid_o SHALL stay stable while tvalid_o && !tready_i.
REQ-023 Simultaneous capture and pop SHALL leave occ unchanged and preserve order.
REQ-024 Latency: the first word SHALL appear on tvalid_o 2 cycles after the cycle fifo_rd_o is first asserted from idle.
REQ-025 With fifo_empty_i low and tready_i held high, the block SHALL sustain one pop per clock with no bubbles.
REQ-026 beat_cnt_o SHALL increment on each pop.
REQ-027 beat_cnt_o SHALL wrap to 0 on the pop where it equals PKT_LEN-1.
REQ-028 tlast_o SHALL equal tvalid_o && (beat_cnt_o == PKT_LEN-1).
REQ-029 With PKT_LEN=1, tlast_o SHALL be high on every valid beat.
REQ-030 beat_cnt_o SHALL NOT change while no pop occurs, including during upstream starvation.
REQ-031 A fifo_empty_i rising edge mid-stream SHALL stop reads; buffered words SHALL still drain normally.

Reset
REQ-032 On rst_n_i low, the block SHALL immediately clear occ, inflight and beat_cnt_o to 0, independent of clk_i.
REQ-033 During reset, outputs SHALL be: tvalid_o=0, tlast_o=0, tdata_o=0, beat_cnt_o=0, fifo_rd_o=0.
REQ-034 A read in flight when reset asserts SHALL be discarded; its data SHALL NOT be captured after reset release.
REQ-035 The first fifo_rd_o after reset release SHALL occur no earlier than the first rising clk_i edge with rst_n_i high.

Verification
REQ-036 Single word: fifo_empty_i low for one read, tready_i=1 -> fifo_rd_o high 1 cycle; tvalid_o high exactly 1 cycle, 2 cycles later, with the FIFO word; beat_cnt_o becomes 1.
REQ-037 Streaming: 40 words, tready_i=1, PKT_LEN=16 -> 40 consecutive beats in order, no gaps; tlast_o on beats 15 and 31; beat_cnt_o=8 at end.
REQ-038 Backpressure: tready_i=0 with 5 words available -> exactly 2 reads issued; tvalid_o high with tdata_o stable; fifo_rd_o low thereafter. tready_i then high -> all 5 words emerge in order.
REQ-039 Random tready_i (50%) and random fifo_empty_i over 1000 words -> scoreboard order match; occ never exceeds 2; no fifo_rd_o while empty.
REQ-040 Reset mid-stream: assert rst_n_i low in the cycle after a fifo_rd_o -> tvalid_o, tlast_o, beat_cnt_o 0 immediately; the returning data is not emitted after release.
REQ-041 PKT_LEN=1: 4 words -> tlast_o high on all 4 beats; beat_cnt_o stays 0.
